handshake_cmpi_share: RTL and testbench
=======================================

Name: handshake_cmpi_share

Overview:
- Time-multiplexes one unsigned less-than comparator (lhs < rhs -> 1-bit result) among NUM_REQ independent handshake requesters.
- Each requester has its own operand pair and result channel, with per-channel valid/ready.
- A round-robin arbiter grants at most one requester per cycle. The compare result is registered into a per-requester one-slot output buffer.
- Sits in the dataflow circuit where resource sharing replaces NUM_REQ separate comparator instances.

Parameters:
- DATA_TYPE, 32, operand width in bits.
- NUM_REQ, 4, number of requesters sharing the comparator (>= 2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- lhs  input  NUM_REQ*DATA_TYPE  left operands, requester i in bits [i*DATA_TYPE +: DATA_TYPE].
- lhs_valid  input  NUM_REQ  per-requester lhs valid.
- lhs_ready  output  NUM_REQ  per-requester lhs ready.
- rhs  input  NUM_REQ*DATA_TYPE  right operands, same packing as lhs.
- rhs_valid  input  NUM_REQ  per-requester rhs valid.
- rhs_ready  output  NUM_REQ  per-requester rhs ready.
- result  output  NUM_REQ  per-requester compare result.
- result_valid  output  NUM_REQ  per-requester result valid.
- result_ready  input  NUM_REQ  per-requester downstream ready.

Behaviour:
- Reset: while rst=1 at a clock edge, result_valid=0, result=0, and the round-robin pointer ptr=0. lhs_ready/rhs_ready are combinational and are 0 whenever there is no grant.
- Eligibility of requester i: lhs_valid[i] & rhs_valid[i] & slot_free[i], where slot_free[i] = !result_valid[i] | result_ready[i]. A slot being drained in the same cycle counts as free.
- Arbitration (combinational, same cycle):
  - Search starts at index ptr and proceeds upward, wrapping modulo NUM_REQ.
  - The first eligible requester g is granted. At most one grant per cycle.
- Grant effects:
  - Same cycle: lhs_ready[g]=rhs_ready[g]=1; all other ready bits are 0.
  - No partial consumption: a requester with only one operand valid gets no ready on either operand.
  - Next edge: result[g] <= (lhs_g < rhs_g), unsigned compare over DATA_TYPE bits; result_valid[g] <= 1; ptr <= (g+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
- No grant in a cycle: ptr unchanged.
- Output slot i, when not granted:
  - If result_valid[i] & result_ready[i], then result_valid[i] <= 0.
  - Otherwise result_valid[i] and result[i] hold.
- Simultaneous drain and grant on the same slot: the slot reloads with the new result and result_valid stays 1.
- Latency and throughput:
  - Operand handshake to result_valid is exactly 1 cycle.
  - Sustained throughput is 1 compare/cycle in aggregate.
  - Any persistently eligible requester is granted within NUM_REQ cycles (starvation-free).
- Backpressure: a requester whose slot is full and not draining is skipped and never blocks the others.
- Reset mid-operation: in-flight slot contents are discarded (result_valid=0) and ptr returns to 0. Operands are not acknowledged during the reset cycle.
- Handshake rule: result_valid/result never depend combinationally on result_ready of the same channel (registered outputs).

Optional Feature:
- Macro HANDSHAKE_CMPI_SHARE_SIGNED_EN.
- Defined: the comparison is two's-complement signed less-than on DATA_TYPE bits.
- Undefined (default): the comparison is unsigned less-than.
- Arbitration, handshake and latency are identical in both builds.

Decomposition:
- Shared package handshake_share_pkg holds:
  - function clog2-based REQ_IDX_W (index width for NUM_REQ, minimum 1);
  - the operand-slice helper (lhs packing offset);
  - the grant one-hot/index conversion function.
- One natural sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs clk, rst, req[NUM_REQ], advance.
  - Outputs gnt_onehot[NUM_REQ], gnt_idx, gnt_any.
  - Owns ptr and its synchronous reset.
- The top module holds the comparator and the output slots.

Test Plan:
1. Reset then idle: assert rst 2 cycles, all valids 0 -> result_valid=0000, all ready bits 0, ptr=0.
2. Single requester: req1 lhs=5, rhs=9, both valid, result_ready=1 -> lhs_ready[1]=rhs_ready[1]=1 that cycle; next cycle result_valid[1]=1, result[1]=1. Repeat with lhs=9, rhs=5 -> result[1]=0.
3. Round-robin fairness: all 4 requesters valid continuously, all result_ready=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles, one result_valid per cycle.
4. Backpressure: req2 has result_valid=1, result_ready[2]=0; req2 and req3 offer operands -> req2 not granted, req3 granted, req2 result held stable. Then raise result_ready[2] -> req2 granted the same cycle as the drain, and result_valid[2] stays 1 with the new value.
5. Partial operands and boundaries: req0 lhs_valid only -> no ready to req0. Unsigned edge lhs=0xFFFFFFFF, rhs=0 -> result 0. Equal operands 7,7 -> result 0. With HANDSHAKE_CMPI_SHARE_SIGNED_EN defined, 0xFFFFFFFF vs 0 -> result 1.
6. Reset mid-operation: assert rst while result_valid=0110 and operands pending -> next cycle result_valid=0000, ptr=0, no operand readies asserted during reset.

Source files
------------

// File: rtl/handshake_share_pkg.sv
// -----------------------------------------------------------------------------
// handshake_share_pkg
// Shared helpers for the comparator-sharing handshake block:
//   req_idx_w     : index width needed to address NUM_REQ requesters (min 1)
//   slice_lo      : low bit offset of requester idx in a packed operand bus
//   onehot_to_idx : converts a one-hot grant vector (up to MAX_REQ bits) to
//                   its binary index
// -----------------------------------------------------------------------------
package handshake_share_pkg;

  // Widest grant vector the one-hot converter accepts.
  localparam int unsigned MAX_REQ = 64;

  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  // OR-reduction form: correct for a one-hot (or all-zero) input.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | int'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/handshake_cmpi_share_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at ptr and wraps modulo NUM_REQ; the
// first requesting index wins. ptr moves to one past the winner when advance
// is high and a grant exists, and otherwise holds.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (ptr -> 0)
//   req           : per-requester request
//   advance       : the current grant is being consumed
//   gnt_onehot    : one-hot grant (all zero when nothing requests)
//   gnt_idx       : binary index of the grant
//   gnt_any       : a grant exists this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
  import handshake_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = int'(req_idx_w(NUM_REQ))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic found;
    found      = 1'b0;
    gnt_onehot = '0;
    // k is the distance from ptr in rotated priority order.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && ((int'(ptr_q) + k) % NUM_REQ) == i) begin
          gnt_onehot[i] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    gnt_any = found;
    gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_onehot)));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && gnt_any) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/handshake_cmpi_share.sv
// -----------------------------------------------------------------------------
// handshake_cmpi_share
// One less-than comparator shared among NUM_REQ handshake requesters. A
// round-robin arbiter picks one requester with both operands valid and a free
// (or draining) result slot; its operands are acknowledged in the same cycle
// and the compare result lands in that requester's one-slot output register on
// the next edge.
// Build option: define HANDSHAKE_CMPI_SHARE_SIGNED_EN for a two's-complement
// signed compare; the default build compares unsigned.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   lhs, rhs                : packed operands, requester i at [i*DATA_TYPE +: DATA_TYPE]
//   lhs_valid/lhs_ready     : per-requester left operand handshake
//   rhs_valid/rhs_ready     : per-requester right operand handshake
//   result/result_valid     : per-requester registered compare result
//   result_ready            : per-requester downstream ready
// -----------------------------------------------------------------------------
module handshake_cmpi_share
  import handshake_share_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0] lhs,
  input  logic [NUM_REQ-1:0]           lhs_valid,
  output logic [NUM_REQ-1:0]           lhs_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0] rhs,
  input  logic [NUM_REQ-1:0]           rhs_valid,
  output logic [NUM_REQ-1:0]           rhs_ready,
  output logic [NUM_REQ-1:0]           result,
  output logic [NUM_REQ-1:0]           result_valid,
  input  logic [NUM_REQ-1:0]           result_ready
);

  localparam int IDX_W = int'(req_idx_w(NUM_REQ));

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [DATA_TYPE-1:0] lhs_p0, rhs_p0;
  logic                 cmp_p0;
  logic [NUM_REQ-1:0]   result_d, result_q;
  logic [NUM_REQ-1:0]   result_valid_d, result_valid_q;

  function automatic logic less_than(input logic [DATA_TYPE-1:0] a,
                                     input logic [DATA_TYPE-1:0] b);
`ifdef HANDSHAKE_CMPI_SHARE_SIGNED_EN
    logic signed [DATA_TYPE-1:0] sa, sb;
    sa = a;
    sb = b;
    return sa < sb;
`else
    return a < b;
`endif
  endfunction

  // Requests are masked during reset so no operand is acknowledged then.
  assign req = lhs_valid & rhs_valid & (~result_valid_q | result_ready)
             & {NUM_REQ{~rst}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .advance    (gnt_any),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign lhs_ready = gnt_oh;
  assign rhs_ready = gnt_oh;

  // ---- p0: operand select and shared compare ----
  always_comb begin
    lhs_p0 = '0;
    rhs_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == IDX_W'(i)) begin
        lhs_p0 = lhs[slice_lo(i, DATA_TYPE) +: DATA_TYPE];
        rhs_p0 = rhs[slice_lo(i, DATA_TYPE) +: DATA_TYPE];
      end
    end
    cmp_p0 = less_than(lhs_p0, rhs_p0);
  end

  // ---- p1: per-requester result slots ----
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        // A grant wins over a same-cycle drain: the slot simply reloads.
        result_d[i]       = cmp_p0;
        result_valid_d[i] = 1'b1;
      end else if (result_valid_q[i] && result_ready[i]) begin
        result_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q       <= '0;
      result_valid_q <= '0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_handshake_cmpi_share.sv
module tb_handshake_cmpi_share;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] lhs, rhs;
  logic [N-1:0]   lhs_valid, rhs_valid, lhs_ready, rhs_ready;
  logic [N-1:0]   result, result_valid, result_ready;

  logic [W-1:0]   la [N];
  logic [W-1:0]   ra [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lhs[i*W +: W] = la[i];
      rhs[i*W +: W] = ra[i];
    end
  end

  handshake_cmpi_share #(.DATA_TYPE(W), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .lhs_valid    (lhs_valid),
    .lhs_ready    (lhs_ready),
    .rhs          (rhs),
    .rhs_valid    (rhs_valid),
    .rhs_ready    (rhs_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_vld, m_res;
  int           m_ptr;
  bit           m_on = 1'b0;

  function automatic bit ref_lt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef HANDSHAKE_CMPI_SHARE_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Which requester should win right now (-1 for none).
  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (lhs_valid[i] && rhs_valid[i] && (!m_vld[i] || result_ready[i])) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_vld <= '0;
      m_res <= '0;
      m_ptr <= 0;
      m_on  <= 1'b1;
    end else if (m_on) begin
      g = model_grant();
      for (int i = 0; i < N; i++) begin
        if (i == g) begin
          m_res[i] <= ref_lt(la[i], ra[i]);
          m_vld[i] <= 1'b1;
        end else if (m_vld[i] && result_ready[i]) begin
          m_vld[i] <= 1'b0;
        end
      end
      if (g >= 0) m_ptr <= (g + 1) % N;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (m_on) begin
      g  = model_grant();
      er = (g >= 0) ? (N'(1) << g) : '0;
      check("mdl_lhs_ready", 32'(lhs_ready), 32'(er));
      check("mdl_rhs_ready", 32'(rhs_ready), 32'(er));
      check("mdl_result_valid", 32'(result_valid), 32'(m_vld));
      check("mdl_result", 32'(result), 32'(m_res));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
    la[i]        = l;
    ra[i]        = r;
    lhs_valid[i] = 1'b1;
    rhs_valid[i] = 1'b1;
  endtask

  task automatic clear_ops();
    lhs_valid = '0;
    rhs_valid = '0;
  endtask

  initial begin
    logic [N-1:0] t3_exp [6];
    t3_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst          = 1'b1;
    result_ready = '0;
    for (int i = 0; i < N; i++) begin
      la[i] = '0;
      ra[i] = '0;
    end
    clear_ops();

    // 1. reset then idle
    step();
    step();
    check("rst_result_valid", 32'(result_valid), 32'h0);
    check("rst_lhs_ready", 32'(lhs_ready), 32'h0);
    rst = 1'b0;
    step();
    check("idle_result_valid", 32'(result_valid), 32'h0);

    // 2. single requester
    result_ready = '1;
    set_op(1, 32'd5, 32'd9);
    #1;
    check("t2_lhs_ready", 32'(lhs_ready), 32'b0010);
    check("t2_rhs_ready", 32'(rhs_ready), 32'b0010);
    step();
    clear_ops();
    check("t2_valid_a", 32'(result_valid), 32'b0010);
    check("t2_result_a", 32'(result[1]), 32'd1);
    set_op(1, 32'd9, 32'd5);
    step();
    clear_ops();
    check("t2_valid_b", 32'(result_valid[1]), 32'd1);
    check("t2_result_b", 32'(result[1]), 32'd0);
    step();
    check("t2_drain", 32'(result_valid), 32'h0);

    // 3. round-robin fairness from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, W'(i), 32'd2);
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t3_grant", 32'(lhs_ready), 32'(t3_exp[c]));
      step();
      check("t3_one_valid", 32'(result_valid), 32'(t3_exp[c]));
    end
    clear_ops();
    step();

    // 4. backpressure: slot 2 full and stalled is skipped, then drain+reload
    result_ready = 4'b1011;
    set_op(2, 32'd1, 32'd2);
    #1;
    check("t4_fill2", 32'(lhs_ready), 32'b0100);
    step();
    clear_ops();
    check("t4_res2_a", 32'(result[2]), 32'd1);
    set_op(1, 32'd4, 32'd4);
    #1;
    check("t4_g1", 32'(lhs_ready), 32'b0010);
    step();
    clear_ops();
    set_op(2, 32'd3, 32'd1);
    set_op(3, 32'd1, 32'd2);
    #1;
    check("t4_skip2", 32'(lhs_ready), 32'b1000);
    step();
    lhs_valid[3] = 1'b0;
    rhs_valid[3] = 1'b0;
    check("t4_hold_vld2", 32'(result_valid[2]), 32'd1);
    check("t4_hold_res2", 32'(result[2]), 32'd1);
    result_ready = '1;
    #1;
    check("t4_drain_grant", 32'(lhs_ready), 32'b0100);
    step();
    clear_ops();
    check("t4_reload_vld", 32'(result_valid[2]), 32'd1);
    check("t4_reload_res", 32'(result[2]), 32'd0);

    // 5. partial operands and compare boundaries
    la[0] = 32'd3;
    lhs_valid[0] = 1'b1;
    #1;
    check("t5_partial_l", 32'(lhs_ready), 32'h0);
    check("t5_partial_r", 32'(rhs_ready), 32'h0);
    step();
    clear_ops();
    set_op(0, 32'hFFFF_FFFF, 32'h0);
    step();
    clear_ops();
`ifdef HANDSHAKE_CMPI_SHARE_SIGNED_EN
    check("t5_max_vs_0", 32'(result[0]), 32'd1);
`else
    check("t5_max_vs_0", 32'(result[0]), 32'd0);
`endif
    set_op(0, 32'd7, 32'd7);
    step();
    clear_ops();
    check("t5_equal", 32'(result[0]), 32'd0);
    set_op(0, 32'h0, 32'hFFFF_FFFF);
    step();
    clear_ops();
`ifdef HANDSHAKE_CMPI_SHARE_SIGNED_EN
    check("t5_0_vs_max", 32'(result[0]), 32'd0);
`else
    check("t5_0_vs_max", 32'(result[0]), 32'd1);
`endif
    step();

    // 6. reset mid-operation
    result_ready = '0;
    set_op(1, 32'd1, 32'd2);
    step();
    clear_ops();
    set_op(2, 32'd1, 32'd2);
    step();
    clear_ops();
    check("t6_pre_valid", 32'(result_valid), 32'b0110);
    for (int i = 0; i < N; i++) set_op(i, 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_lrdy", 32'(lhs_ready), 32'h0);
    check("t6_rst_rrdy", 32'(rhs_ready), 32'h0);
    step();
    check("t6_flushed", 32'(result_valid), 32'h0);
    rst = 1'b0;
    result_ready = '1;
    #1;
    check("t6_ptr0_grant", 32'(lhs_ready), 32'b0001);
    step();
    clear_ops();
    check("t6_after_valid", 32'(result_valid), 32'b0001);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
